// File: rtl/sensor_snapshot_hub_pkg.sv
// Shared definitions for the sensor snapshot hub.
//   - Button/command bit positions within the controller vector
//   - Hub FSM state type
//   - Field-offset helper for the packed sensor frame
package sensor_snapshot_hub_pkg;

  localparam int unsigned NUM_CMDS   = 4;
  localparam int unsigned CMD_SAVE   = 0;
  localparam int unsigned CMD_LOAD   = 1;
  localparam int unsigned CMD_ADV    = 2;
  localparam int unsigned CMD_UNLOAD = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_LOAD,
    ST_SCAN
  } hub_state_e;

  // LSB position of field idx in a frame of width-bit fields.
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sensor_snapshot_hub_if.sv
// Bus bundle between the snapshot hub and its neighbours.
//   sensor_input   : live packed frame from the board sensor bus
//   controller     : raw buttons {unload, advance, load, save}
//   frame_out      : loaded snapshot or registered live frame
//   save_signal / load_signal / load_err : one-cycle event pulses
//   state_load_out : {mode_loaded, slot_ptr}
//   slot_valid     : per-slot occupied flags
//   sensor_output  : first mismatching field index + 1 (0 = none)
//   match_all      : last completed sweep matched every field
// modport slave is the hub side, master is the driving/observing side.
interface sensor_snapshot_hub_if #(
  parameter int unsigned NUM_SENSORS = 8,
  parameter int unsigned SENSOR_W    = 3,
  parameter int unsigned NUM_SLOTS   = 4
);
  localparam int unsigned FRAME_W = NUM_SENSORS * SENSOR_W;
  localparam int unsigned SLOT_W  = $clog2(NUM_SLOTS);
  localparam int unsigned OUT_W   = $clog2(NUM_SENSORS + 1);

  logic [FRAME_W-1:0]   sensor_input;
  logic [3:0]           controller;
  logic [FRAME_W-1:0]   frame_out;
  logic                 save_signal;
  logic                 load_signal;
  logic                 load_err;
  logic [SLOT_W:0]      state_load_out;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [OUT_W-1:0]     sensor_output;
  logic                 match_all;

  modport master (
    output sensor_input, controller,
    input  frame_out, save_signal, load_signal, load_err,
           state_load_out, slot_valid, sensor_output, match_all
  );

  modport slave (
    input  sensor_input, controller,
    output frame_out, save_signal, load_signal, load_err,
           state_load_out, slot_valid, sensor_output, match_all
  );

endinterface

// File: rtl/sensor_snapshot_hub_debouncer.sv
// Single-bit button debouncer.
//   clock, reset : system clock, synchronous active-high reset
//   raw          : raw button level
//   cmd          : one-cycle pulse when the debounced level rises
// The accepted level changes after DEBOUNCE_CYC consecutive cycles in
// which raw differs from it; any agreeing cycle restarts the count.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic cmd
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);

  logic [CNT_W-1:0] cnt;
  logic             deb;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      deb <= 1'b0;
      cmd <= 1'b0;
    end else begin
      cmd <= 1'b0;
      if (raw != deb) begin
        if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          deb <= raw;
          cnt <= '0;
          cmd <= raw;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sensor_snapshot_hub.sv
// Sensor snapshot hub.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : sensor frame in, raw buttons in, frame/status out
// Debounced buttons issue save/load/advance/unload commands. Snapshots of
// the registered live frame are kept in NUM_SLOTS slots. While a snapshot
// is loaded, a one-field-per-cycle sweep reports the first field where the
// live frame differs from it.
module sensor_snapshot_hub
  import sensor_snapshot_hub_pkg::*;
#(
  parameter int unsigned NUM_SENSORS  = 8,
  parameter int unsigned SENSOR_W     = 3,
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input logic            clock,
  input logic            reset,
  sensor_snapshot_hub_if.slave bus
);

  localparam int unsigned FRAME_W = NUM_SENSORS * SENSOR_W;
  localparam int unsigned SLOT_W  = $clog2(NUM_SLOTS);
  localparam int unsigned OUT_W   = $clog2(NUM_SENSORS + 1);
  localparam int unsigned IDX_W   = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

  logic [FRAME_W-1:0]   live_q;
  logic [FRAME_W-1:0]   loaded_frame;
  logic [FRAME_W-1:0]   slots [NUM_SLOTS];
  logic [NUM_CMDS-1:0]  cmd;

  hub_state_e           state;
  logic                 mode_loaded;
  logic [SLOT_W-1:0]    slot_ptr;
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [IDX_W-1:0]     scan_idx;
  logic [IDX_W-1:0]     cand_idx;
  logic                 cand_found;
  logic                 save_q;
  logic                 load_q;
  logic                 err_q;
  logic [OUT_W-1:0]     sensor_q;
  logic                 match_q;

  logic                 accept;
  logic                 field_diff;
  logic                 slot_we;

  for (genvar b = 0; b < NUM_CMDS; b++) begin : g_deb
    button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clock (clock),
      .reset (reset),
      .raw   (bus.controller[b]),
      .cmd   (cmd[b])
    );
  end

  always_comb begin
    accept     = ((state == ST_IDLE) || (state == ST_SCAN)) && (|cmd);
    field_diff = live_q[field_lsb(32'(scan_idx), SENSOR_W) +: SENSOR_W]
              != loaded_frame[field_lsb(32'(scan_idx), SENSOR_W) +: SENSOR_W];
    slot_we    = !reset && !accept && (state == ST_SAVE);
  end

  always_ff @(posedge clock) begin
    if (reset) live_q <= '0;
    else       live_q <= bus.sensor_input;
  end

  // Slot storage carries no reset so it can map onto plain RAM/registers.
  always_ff @(posedge clock) begin
    if (slot_we) slots[slot_ptr] <= live_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode_loaded  <= 1'b0;
      slot_ptr     <= '0;
      slot_valid   <= '0;
      loaded_frame <= '0;
      scan_idx     <= '0;
      cand_idx     <= '0;
      cand_found   <= 1'b0;
      save_q       <= 1'b0;
      load_q       <= 1'b0;
      err_q        <= 1'b0;
      sensor_q     <= '0;
      match_q      <= 1'b0;
    end else begin
      save_q <= 1'b0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        // Any accepted command restarts the sweep; published results hold.
        scan_idx   <= '0;
        cand_found <= 1'b0;
        if (cmd[CMD_SAVE]) begin
          state <= ST_SAVE;
        end else if (cmd[CMD_LOAD]) begin
          state <= ST_LOAD;
        end else if (cmd[CMD_UNLOAD]) begin
          mode_loaded <= 1'b0;
          state       <= ST_IDLE;
          sensor_q    <= '0;
          match_q     <= 1'b0;
        end else begin
          slot_ptr <= slot_ptr + 1'b1;
        end
      end else begin
        case (state)
          ST_SAVE: begin
            slot_valid[slot_ptr] <= 1'b1;
            save_q               <= 1'b1;
            // SAVE/LOAD are only entered from IDLE or SCAN, and SCAN is
            // exactly the loaded case, so mode_loaded recovers the origin.
            state <= mode_loaded ? ST_SCAN : ST_IDLE;
          end
          ST_LOAD: begin
            if (slot_valid[slot_ptr]) begin
              loaded_frame <= slots[slot_ptr];
              mode_loaded  <= 1'b1;
              load_q       <= 1'b1;
              state        <= ST_SCAN;
            end else begin
              err_q <= 1'b1;
              state <= mode_loaded ? ST_SCAN : ST_IDLE;
            end
          end
          ST_SCAN: begin
            if (scan_idx == IDX_W'(NUM_SENSORS - 1)) begin
              // Last field: fold its own comparison into the published result.
              if (cand_found)      sensor_q <= OUT_W'(cand_idx) + OUT_W'(1);
              else if (field_diff) sensor_q <= OUT_W'(NUM_SENSORS);
              else                 sensor_q <= '0;
              match_q    <= !(cand_found || field_diff);
              scan_idx   <= '0;
              cand_found <= 1'b0;
            end else begin
              scan_idx <= scan_idx + 1'b1;
              if (field_diff && !cand_found) begin
                cand_found <= 1'b1;
                cand_idx   <= scan_idx;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.frame_out      = mode_loaded ? loaded_frame : live_q;
  assign bus.save_signal    = save_q;
  assign bus.load_signal    = load_q;
  assign bus.load_err       = err_q;
  assign bus.state_load_out = {mode_loaded, slot_ptr};
  assign bus.slot_valid     = slot_valid;
  assign bus.sensor_output  = sensor_q;
  assign bus.match_all      = match_q;

endmodule

// File: tb/tb_sensor_snapshot_hub.sv
module tb_sensor_snapshot_hub;

  localparam int NS  = 8;
  localparam int SW  = 3;
  localparam int NSL = 4;
  localparam int DB  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sensor_snapshot_hub_if #(.NUM_SENSORS(NS), .SENSOR_W(SW), .NUM_SLOTS(NSL)) bus ();

  sensor_snapshot_hub #(
    .NUM_SENSORS(NS), .SENSOR_W(SW), .NUM_SLOTS(NSL), .DEBOUNCE_CYC(DB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int save_cnt = 0, load_cnt = 0, err_cnt = 0, save_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [23:0] m_live, m_lframe;
  logic [23:0] m_slot [NSL];
  logic [3:0]  m_valid;
  int          m_ptr;
  bit          m_loaded;
  int          m_pending;   // 0 none, 1 save in progress, 2 load in progress
  bit          m_save, m_load, m_err, m_ma;
  int          m_so;
  int          m_pos;
  bit          m_diff [NS];
  bit [3:0]    m_deb, m_cmd;
  int          m_cnt [4];

  function automatic int field(input logic [23:0] f, input int i);
    return int'((f >> (i * SW)) & 24'h7);
  endfunction

  task automatic model_step();
    bit [3:0]    c;
    logic [23:0] live_old;
    int          first;
    c        = m_cmd;
    live_old = m_live;
    if (reset) begin
      m_live = '0; m_lframe = '0; m_valid = '0; m_ptr = 0; m_loaded = 0;
      m_pending = 0; m_save = 0; m_load = 0; m_err = 0; m_ma = 0; m_so = 0;
      m_pos = 0; m_deb = '0; m_cmd = '0;
      for (int b = 0; b < 4; b++) m_cnt[b] = 0;
      return;
    end
    m_save = 0; m_load = 0; m_err = 0;
    if (m_pending == 0 && c != 4'b0) begin
      m_pos = 0;
      if (c[0])      m_pending = 1;
      else if (c[1]) m_pending = 2;
      else if (c[3]) begin m_loaded = 0; m_so = 0; m_ma = 0; end
      else           m_ptr = (m_ptr + 1) % NSL;
    end else if (m_pending == 1) begin
      m_slot[m_ptr]  = live_old;
      m_valid[m_ptr] = 1'b1;
      m_save         = 1;
      m_pending      = 0;
    end else if (m_pending == 2) begin
      if (m_valid[m_ptr]) begin
        m_lframe = m_slot[m_ptr]; m_loaded = 1; m_load = 1;
      end else begin
        m_err = 1;
      end
      m_pending = 0;
    end else if (m_loaded) begin
      m_diff[m_pos] = field(live_old, m_pos) != field(m_lframe, m_pos);
      if (m_pos == NS - 1) begin
        first = -1;
        for (int i = 0; i < NS; i++) if (m_diff[i] && first < 0) first = i;
        m_so  = first + 1;
        m_ma  = (first < 0);
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      m_cmd[b] = 1'b0;
      if (bus.controller[b] != m_deb[b]) begin
        m_cnt[b]++;
        if (m_cnt[b] == DB) begin
          m_deb[b] = bus.controller[b];
          m_cnt[b] = 0;
          m_cmd[b] = bus.controller[b];
        end
      end else begin
        m_cnt[b] = 0;
      end
    end
    m_live = bus.sensor_input;
  endtask

  always @(posedge clock) begin
    model_step();
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (cyc > 0) begin
      check("frame_out", 32'(bus.frame_out), 32'(m_loaded ? m_lframe : m_live));
      check("save_signal", 32'(bus.save_signal), 32'(m_save));
      check("load_signal", 32'(bus.load_signal), 32'(m_load));
      check("load_err", 32'(bus.load_err), 32'(m_err));
      check("state_load_out", 32'(bus.state_load_out), 32'({m_loaded, 2'(m_ptr)}));
      check("slot_valid", 32'(bus.slot_valid), 32'(m_valid));
      check("sensor_output", 32'(bus.sensor_output), 32'(m_so));
      check("match_all", 32'(bus.match_all), 32'(m_ma));
      if (bus.save_signal === 1'b1) begin save_cnt++; save_cyc = cyc; end
      if (bus.load_signal === 1'b1) load_cnt++;
      if (bus.load_err === 1'b1) err_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int b);
    bus.controller[b] = 1'b1;
    tick(6);
    bus.controller[b] = 1'b0;
    tick(6);
  endtask

  initial begin
    int hi [3] = '{2, 3, 1};
    int lo [3] = '{2, 1, 3};
    int t0, s0, l0, e0;
    logic [23:0] base;
    base = 24'h0F0F0F;
    bus.controller   = 4'b0;
    bus.sensor_input = 24'h123456;
    reset = 1'b1;
    tick(3);
    check("reset_frame_out", 32'(bus.frame_out), 32'h0);
    check("reset_state_load_out", 32'(bus.state_load_out), 32'h0);
    check("reset_slot_valid", 32'(bus.slot_valid), 32'h0);
    check("reset_sensor_output", 32'(bus.sensor_output), 32'h0);
    reset = 1'b0;
    tick(2);

    // Bounce: glitches shorter than the debounce window, then a stable press.
    for (int i = 0; i < 3; i++) begin
      bus.controller[0] = 1'b1; tick(hi[i]);
      bus.controller[0] = 1'b0; tick(lo[i]);
    end
    tick(4);
    check("glitch_no_save", 32'(save_cnt), 32'd0);
    t0 = cyc;
    bus.controller[0] = 1'b1; tick(10);
    bus.controller[0] = 1'b0; tick(8);
    check("bounce_save_count", 32'(save_cnt), 32'd1);
    check("bounce_latency", 32'(save_cyc - t0), 32'd6);

    // Save/load roundtrip.
    bus.sensor_input = 24'hABCDEF; tick(2);
    l0 = load_cnt;
    press(1);
    check("roundtrip_frame", 32'(bus.frame_out), 32'h123456);
    check("roundtrip_state", 32'(bus.state_load_out), 32'b100);
    check("roundtrip_load_pulse", 32'(load_cnt - l0), 32'd1);

    // Unload, advance to slot 2, load from empty slot.
    press(3);
    check("unload_live_frame", 32'(bus.frame_out), 32'hABCDEF);
    press(2); press(2);
    e0 = err_cnt;
    press(1);
    check("empty_load_err", 32'(err_cnt - e0), 32'd1);
    check("empty_state", 32'(bus.state_load_out), 32'b010);
    check("empty_frame_live", 32'(bus.frame_out), 32'hABCDEF);
    press(2); press(2);
    check("adv_wrap", 32'(bus.state_load_out), 32'b000);

    // Scan: snapshot all-zero, then perturb fields.
    bus.sensor_input = 24'h0; tick(2);
    press(0); press(1);
    check("scan_loaded", 32'(bus.state_load_out), 32'b100);
    tick(20);
    check("scan_zero_match", 32'(bus.match_all), 32'd1);
    bus.sensor_input = (24'd7 << 15) | (24'd1 << 6); tick(20);
    check("scan_first_f2", 32'(bus.sensor_output), 32'd3);
    check("scan_mismatch", 32'(bus.match_all), 32'd0);
    bus.sensor_input = 24'd7 << 15; tick(20);
    check("scan_first_f5", 32'(bus.sensor_output), 32'd6);
    bus.sensor_input = 24'h0; tick(20);
    check("scan_clear_out", 32'(bus.sensor_output), 32'd0);
    check("scan_clear_match", 32'(bus.match_all), 32'd1);

    // Simultaneous save + advance: save wins, pointer unchanged.
    s0 = save_cnt;
    bus.controller = 4'b0101; tick(6);
    bus.controller = 4'b0000; tick(6);
    check("simul_save_once", 32'(save_cnt - s0), 32'd1);
    check("simul_no_advance", 32'(bus.state_load_out), 32'b100);

    // Reset while scanning.
    tick(3);
    reset = 1'b1; tick(1);
    check("rst_scan_state", 32'(bus.state_load_out), 32'h0);
    check("rst_scan_valid", 32'(bus.slot_valid), 32'h0);
    check("rst_scan_frame", 32'(bus.frame_out), 32'h0);
    check("rst_scan_match", 32'(bus.match_all), 32'h0);
    reset = 1'b0;
    tick(2);

    // Randomized phase, checked cycle by cycle against the model.
    for (int k = 0; k < 300; k++) begin
      bus.controller = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: bus.sensor_input = base;
        1: bus.sensor_input = base ^ (24'd1 << (SW * $urandom_range(0, NS - 1)));
        2: bus.sensor_input = 24'($urandom);
        default: ;
      endcase
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1; tick(1); reset = 1'b0;
      end
      tick($urandom_range(1, 8));
    end
    bus.controller = 4'b0;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
